instr_fetch_buffer: RTL

// Instruction word prefetch buffer feeding the standardizer (instruction decoder).

---
 rtl/instr_fetch_buffer.sv | 112 +++++++++++
 1 files changed

// File: rtl/instr_fetch_buffer.sv
// Instruction word prefetch buffer: sequential 64-bit word fetch into a
// small FIFO, head word presented to the standardizer one half at a time.
// Optional feature macro: IFB_BYPASS_EN (combinational mem_data -> dc path
// when the FIFO is empty).
module instr_fetch_buffer #(
   parameter int                DEPTH      = 2,
   parameter int                ADDR_W     = 15,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] fetch_addr,
   input  logic [63:0]       mem_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              jump_half,
   output logic [63:0]       dc,
   output logic              tkk,
   output logic              cmd_valid,
   input  logic              cmd_next,
   output logic [ADDR_W-1:0] pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] fetch_q, fetch_d, pc_q, pc_d;
   logic              tkk_q, tkk_d;
   logic [63:0]       mem_q [DEPTH];

   logic empty, full, accept, bypass, consume, pop, wr_en, fifo_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));

   // Readiness depends only on state, jump and reset, never on cmd_next.
   assign mem_ready = !full && !jump && !reset;
   assign accept    = mem_valid && mem_ready;

`ifdef IFB_BYPASS_EN
   assign bypass = empty && accept;
`else
   assign bypass = 1'b0;
`endif

   assign cmd_valid = !empty || bypass;
   assign dc        = !empty ? mem_q[rd_q] : (bypass ? mem_data : 64'd0);
   assign tkk       = tkk_q;
   assign pc        = pc_q;
   assign fetch_addr = fetch_q;

   // A jump cycle ignores consumption; the right half finishes a word.
   assign consume  = cmd_valid && cmd_next && !jump;
   assign pop      = consume && tkk_q;
   // A bypassed word consumed on its right half never needs storing.
   assign wr_en    = accept && !(bypass && pop);
   assign fifo_pop = pop && !empty;

   // Next-state: jump overrides everything, otherwise push/pop/half-step.
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      fetch_d = fetch_q;
      pc_d    = pc_q;
      tkk_d   = tkk_q;
      if (jump) begin
         wr_d    = '0;
         rd_d    = '0;
         cnt_d   = '0;
         fetch_d = jump_addr;
         pc_d    = jump_addr;
         tkk_d   = jump_half;
      end else begin
         if (accept)   fetch_d = fetch_q + ADDR_W'(1);
         if (wr_en)    wr_d    = wr_q + PW'(1);
         if (fifo_pop) rd_d    = rd_q + PW'(1);
         cnt_d = cnt_q + CW'(wr_en) - CW'(fifo_pop);
         if (consume)  tkk_d   = !tkk_q;
         if (pop)      pc_d    = pc_q + ADDR_W'(1);
      end
   end

   // Control state register; reset drops queued words immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         fetch_q <= RESET_ADDR;
         pc_q    <= RESET_ADDR;
         tkk_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         fetch_q <= fetch_d;
         pc_q    <= pc_d;
         tkk_q   <= tkk_d;
      end
   end

   // Word storage; contents are only observed through the occupancy count.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= mem_data;
   end

endmodule
